// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg_pkg
//  Description : Shared widths, encodings and helpers for the ID/EX pipeline
//                register and its load-use hazard detector.
//  Revision    : 1.0  initial release
// ============================================================================
package id_ex_reg_pkg;

    // Width of a GPR specifier (rs/rt/rd).
    localparam int REG_W      = 5;
    // Width of the write-register select and writeback source select codes.
    localparam int REGDST_W   = 2;
    localparam int MEMTOREG_W = 2;

    // $zero: writes are discarded, so it can never carry a real dependency.
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Write-register select encoding.
    typedef enum logic [REGDST_W-1:0] {
        RD_RT = 2'd0,
        RD_RD = 2'd1,
        RD_RA = 2'd2
    } regdst_e;

    // Writeback source select encoding.
    typedef enum logic [MEMTOREG_W-1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } memtoreg_e;

    // True when an operand is actually read and names the given register.
    function automatic logic reg_match(input logic             used,
                                       input logic [REG_W-1:0] producer,
                                       input logic [REG_W-1:0] consumer);
        return used && (producer == consumer);
    endfunction

endpackage : id_ex_reg_pkg
`default_nettype wire

// File: rtl/id_ex_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detector. Flags an ID-stage
//                instruction that reads the destination of the load now in EX.
//  Revision    : 1.0  initial release
// ============================================================================
module load_use_detect
    import id_ex_reg_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic             id_use_rs_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             haz_o
);

    logic w_load_in_ex;
    logic w_dep;

    // A live load in EX whose target is a real register.
    assign w_load_in_ex = ex_valid_i && ex_memread_i && (ex_rt_i != REG_ZERO);

    // The ID instruction consumes that register through rs or rt.
    assign w_dep = reg_match(id_use_rs_i, ex_rt_i, id_rs_i)
                || reg_match(id_use_rt_i, ex_rt_i, id_rt_i);

    assign haz_o = w_load_in_ex && id_valid_i && w_dep;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register of the 5-stage MIPS core. Captures
//                decode results for EX, detects load-use hazards (one-cycle
//                IF/ID freeze plus bubble) and counts inserted bubbles.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm32,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [ALUOP_W-1:0]    id_aluop,
    input  logic                  id_alusrc,
    input  logic [REGDST_W-1:0]   id_regdst,
    input  logic [MEMTOREG_W-1:0] id_memtoreg,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm32,
    output logic [REG_W-1:0]      ex_rs,
    output logic [REG_W-1:0]      ex_rt,
    output logic [REG_W-1:0]      ex_rd,
    output logic                  ex_use_rs,
    output logic                  ex_use_rt,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic                  ex_alusrc,
    output logic [REGDST_W-1:0]   ex_regdst,
    output logic [MEMTOREG_W-1:0] ex_memtoreg,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // Pipeline state and its next-state values.
    logic                  ex_valid_q,    ex_valid_d;
    logic [DATA_W-1:0]     ex_pc_q,       ex_pc_d;
    logic [DATA_W-1:0]     ex_rd1_q,      ex_rd1_d;
    logic [DATA_W-1:0]     ex_rd2_q,      ex_rd2_d;
    logic [DATA_W-1:0]     ex_imm32_q,    ex_imm32_d;
    logic [REG_W-1:0]      ex_rs_q,       ex_rs_d;
    logic [REG_W-1:0]      ex_rt_q,       ex_rt_d;
    logic [REG_W-1:0]      ex_rd_q,       ex_rd_d;
    logic                  ex_use_rs_q,   ex_use_rs_d;
    logic                  ex_use_rt_q,   ex_use_rt_d;
    logic [ALUOP_W-1:0]    ex_aluop_q,    ex_aluop_d;
    logic                  ex_alusrc_q,   ex_alusrc_d;
    logic [REGDST_W-1:0]   ex_regdst_q,   ex_regdst_d;
    logic [MEMTOREG_W-1:0] ex_memtoreg_q, ex_memtoreg_d;
    logic                  ex_regwrite_q, ex_regwrite_d;
    logic                  ex_memread_q,  ex_memread_d;
    logic                  ex_memwrite_q, ex_memwrite_d;
    logic [CNT_W-1:0]      bubble_cnt_q,  bubble_cnt_d;

    logic w_haz;
    logic w_kill;

    load_use_detect u_load_use_detect (
        .ex_valid_i   (ex_valid_q),
        .ex_memread_i (ex_memread_q),
        .ex_rt_i      (ex_rt_q),
        .id_valid_i   (id_valid),
        .id_use_rs_i  (id_use_rs),
        .id_rs_i      (id_rs),
        .id_use_rt_i  (id_use_rt),
        .id_rt_i      (id_rt),
        .haz_o        (w_haz)
    );

    // A flush already kills the EX slot, so it absorbs the hazard: no freeze
    // and no bubble is counted. Reset likewise overrides any freeze request.
    assign stall_o = w_haz && !flush && !rst;

    // Both a flush and a load-use bubble leave an all-zero EX slot.
    assign w_kill = flush || stall_o;

    // Next-state: capture ID unless the slot is killed; count bubbles, saturating.
    always_comb begin
        ex_valid_d    = id_valid;
        ex_pc_d       = id_pc;
        ex_rd1_d      = id_rd1;
        ex_rd2_d      = id_rd2;
        ex_imm32_d    = id_imm32;
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
        ex_rd_d       = id_rd;
        ex_use_rs_d   = id_use_rs;
        ex_use_rt_d   = id_use_rt;
        ex_aluop_d    = id_aluop;
        ex_alusrc_d   = id_alusrc;
        ex_regdst_d   = id_regdst;
        ex_memtoreg_d = id_memtoreg;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
        ex_memwrite_d = id_memwrite;
        bubble_cnt_d  = bubble_cnt_q;

        if (w_kill) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_rd1_d      = '0;
            ex_rd2_d      = '0;
            ex_imm32_d    = '0;
            ex_rs_d       = '0;
            ex_rt_d       = '0;
            ex_rd_d       = '0;
            ex_use_rs_d   = 1'b0;
            ex_use_rt_d   = 1'b0;
            ex_aluop_d    = '0;
            ex_alusrc_d   = 1'b0;
            ex_regdst_d   = '0;
            ex_memtoreg_d = '0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
        end

        if (stall_o && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rd1_q      <= '0;
            ex_rd2_q      <= '0;
            ex_imm32_q    <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_use_rs_q   <= 1'b0;
            ex_use_rt_q   <= 1'b0;
            ex_aluop_q    <= '0;
            ex_alusrc_q   <= 1'b0;
            ex_regdst_q   <= '0;
            ex_memtoreg_q <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rd1_q      <= ex_rd1_d;
            ex_rd2_q      <= ex_rd2_d;
            ex_imm32_q    <= ex_imm32_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_use_rs_q   <= ex_use_rs_d;
            ex_use_rt_q   <= ex_use_rt_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_regdst_q   <= ex_regdst_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm32    = ex_imm32_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_use_rs   = ex_use_rs_q;
    assign ex_use_rt   = ex_use_rt_q;
    assign ex_aluop    = ex_aluop_q;
    assign ex_alusrc   = ex_alusrc_q;
    assign ex_regdst   = ex_regdst_q;
    assign ex_memtoreg = ex_memtoreg_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_memwrite = ex_memwrite_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule : id_ex_reg
`default_nettype wire
